mux6_rr_arbiter: RTL and testbench

Round-robin arbiter sharing the 32-bit 6:1 datapath mux between six requesters (A..F) and a single downstream consumer. Samples requests, drives the mux select code (1..6 = A..F, 0 = idle) from a register, presents the muxed word with a valid/ready handshake and returns a one-cycle acknowledge to the served requester. Sits between the six producer blocks and the shared 32-bit bus, and instantiates `mux_6x1_32bit` as its datapath.

---
 rtl/mux6_pkg.sv | 49 ++++
 rtl/mux6_rr_pick.sv | 24 ++
 rtl/mux_6x1_32bit.sv | 30 +++
 rtl/mux6_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux6_rr_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mux6_pkg.sv
// Shared constants for the six-source round-robin arbiter: select codes,
// state encodings and small index/select conversion helpers.
package mux6_pkg;

   localparam int NUM_SRC = 6;

   localparam logic [2:0] SEL_IDLE = 3'd0;
   localparam logic [2:0] SEL_A    = 3'd1;
   localparam logic [2:0] SEL_B    = 3'd2;
   localparam logic [2:0] SEL_C    = 3'd3;
   localparam logic [2:0] SEL_D    = 3'd4;
   localparam logic [2:0] SEL_E    = 3'd5;
   localparam logic [2:0] SEL_F    = 3'd6;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Pointer value after reset, so that the first search starts at A.
   localparam logic [2:0] LAST_RST = 3'd5;

   // Source index 0..5 to select code 1..6.
   function automatic logic [2:0] idx_to_sel(input logic [2:0] idx);
      return idx + 3'd1;
   endfunction

   // Select code to one-hot source mask; idle and the unused code map to zero.
   function automatic logic [NUM_SRC-1:0] sel_to_onehot(input logic [2:0] sel);
      logic [NUM_SRC-1:0] mask;
      mask = '0;
      case (sel)
         SEL_A:   mask = 6'b000001;
         SEL_B:   mask = 6'b000010;
         SEL_C:   mask = 6'b000100;
         SEL_D:   mask = 6'b001000;
         SEL_E:   mask = 6'b010000;
         SEL_F:   mask = 6'b100000;
         default: mask = '0;
      endcase
      return mask;
   endfunction

   // (base + off) mod NUM_SRC for base in 0..5 and off in 1..6.
   function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
      int s;
      s = int'(base) + off;
      return 3'(s % NUM_SRC);
   endfunction

endpackage

// File: rtl/mux6_rr_pick.sv
// Pointer-rotated priority picker: searches req starting one past last,
// wrapping, and returns the first requesting index.
module mux6_rr_pick
   import mux6_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [2:0]         last,
   output logic               any,
   output logic [2:0]         win
);

   always_comb begin
      any = 1'b0;
      win = last;
      // Walk from the farthest offset down so the nearest requester wins.
      for (int off = NUM_SRC; off >= 1; off--) begin
         if (req[wrap_idx(last, off)]) begin
            any = 1'b1;
            win = wrap_idx(last, off);
         end
      end
   end

endmodule

// File: rtl/mux_6x1_32bit.sv
// 32-bit six-input datapath mux; select code 1..6 picks A..F, any other
// code drives zero.
module mux_6x1_32bit
   import mux6_pkg::*;
(
   input  logic [2:0]  sel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [31:0] C,
   input  logic [31:0] D,
   input  logic [31:0] E,
   input  logic [31:0] F,
   output logic [31:0] y
);

   always_comb begin
      // NOTE: a default on every path keeps combinational outputs latch-free.
      y = '0;
      case (sel)
         SEL_A:   y = A;
         SEL_B:   y = B;
         SEL_C:   y = C;
         SEL_D:   y = D;
         SEL_E:   y = E;
         SEL_F:   y = F;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/mux6_rr_arbiter.sv
// Round-robin arbiter in front of the shared 32-bit 6:1 mux with a
// valid/ready offer and one-cycle ack. Optional grant hold: MUX6_ARB_LOCK_EN.
module mux6_rr_arbiter
   import mux6_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_SRC-1:0]   req,
   input  logic [31:0]          A,
   input  logic [31:0]          B,
   input  logic [31:0]          C,
   input  logic [31:0]          D,
   input  logic [31:0]          E,
   input  logic [31:0]          F,
`ifdef MUX6_ARB_LOCK_EN
   input  logic                 lock,
`endif
   output logic [2:0]           sel,
   output logic [31:0]          out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NUM_SRC-1:0]   ack,
   output logic [CNT_W-1:0]     xfer_cnt
);

   logic [0:0]         st_q;
   logic [2:0]         sel_q;
   logic [2:0]         last_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               pick_any;
   logic [2:0]         pick_win;
   logic [NUM_SRC-1:0] win_mask;
   logic               win_req;
   logic               hs;
   logic               hold_grant;

   // While busy, last_q equals the winner, so the same picker ranks the
   // current winner lowest when re-arbitrating on a handshake.
   mux6_rr_pick u_pick (
      .req  (req),
      .last (last_q),
      .any  (pick_any),
      .win  (pick_win)
   );

   mux_6x1_32bit u_mux (
      .sel (sel_q),
      .A   (A),
      .B   (B),
      .C   (C),
      .D   (D),
      .E   (E),
      .F   (F),
      .y   (out_data)
   );

   assign win_mask  = sel_to_onehot(sel_q);
   assign win_req   = |(req & win_mask);
   assign out_valid = (st_q == ST_BUSY);
   assign hs        = out_valid & out_ready;
   assign ack       = hs ? win_mask : '0;
   assign sel       = sel_q;
   assign xfer_cnt  = cnt_q;

`ifdef MUX6_ARB_LOCK_EN
   assign hold_grant = lock & win_req;
`else
   assign hold_grant = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_IDLE;
         sel_q  <= SEL_IDLE;
         last_q <= LAST_RST;
         cnt_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every
         // branch sees the pre-edge values of st_q, sel_q and last_q.
         case (st_q)
            ST_IDLE: begin
               if (pick_any) begin
                  st_q   <= ST_BUSY;
                  sel_q  <= idx_to_sel(pick_win);
                  last_q <= pick_win;
               end
            end
            ST_BUSY: begin
               if (hs) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (!hold_grant) begin
                     if (pick_any) begin
                        sel_q  <= idx_to_sel(pick_win);
                        last_q <= pick_win;
                     end else begin
                        st_q  <= ST_IDLE;
                        sel_q <= SEL_IDLE;
                     end
                  end
               end else if (!win_req) begin
                  // Abort: the pointer keeps the aborted grant.
                  st_q  <= ST_IDLE;
                  sel_q <= SEL_IDLE;
               end
            end
            default: begin
               st_q  <= ST_IDLE;
               sel_q <= SEL_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Self-checking bench for mux6_rr_arbiter: a per-cycle vector table plus
// hand sequences for counter wrap, mid-transfer reset and the grant lock.
module tb_mux6_rr_arbiter;

   localparam int CW = 4;

   typedef struct {
      logic          rst_n;
      logic [5:0]    req;
      logic          rdy;
      logic [2:0]    sel;
      logic          valid;
      logic [5:0]    ack;
      logic [CW-1:0] cnt;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    req = '0;
   logic          out_ready = 1'b0;
   logic          lock = 1'b0;
   logic [31:0]   A = 32'h1111_1111;
   logic [31:0]   B = 32'h2222_2222;
   logic [31:0]   C = 32'h3333_3333;
   logic [31:0]   D = 32'h4444_4444;
   logic [31:0]   E = 32'h5555_5555;
   logic [31:0]   F = 32'h6666_6666;
   logic [2:0]    sel;
   logic [31:0]   out_data;
   logic          out_valid;
   logic [5:0]    ack;
   logic [CW-1:0] xfer_cnt;

   int n_pass = 0;
   int n_total = 0;

   vec_t vecs [25];

   always #5 clk = ~clk;

   mux6_rr_arbiter #(.CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .E         (E),
      .F         (F),
`ifdef MUX6_ARB_LOCK_EN
      .lock      (lock),
`endif
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ack       (ack),
      .xfer_cnt  (xfer_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] exp_data(input logic [2:0] s);
      case (s)
         3'd1: return 32'h1111_1111;
         3'd2: return 32'h2222_2222;
         3'd3: return 32'h3333_3333;
         3'd4: return 32'h4444_4444;
         3'd5: return 32'h5555_5555;
         3'd6: return 32'h6666_6666;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      //          rst  req     rdy  sel   val   ack      cnt
      vecs[0]  = '{1'b1, 6'h01, 1'b1, 3'd0, 1'b0, 6'h00, 4'd0};
      vecs[1]  = '{1'b1, 6'h00, 1'b1, 3'd1, 1'b1, 6'h01, 4'd0};
      vecs[2]  = '{1'b1, 6'h00, 1'b1, 3'd0, 1'b0, 6'h00, 4'd1};
      vecs[3]  = '{1'b0, 6'h00, 1'b1, 3'd0, 1'b0, 6'h00, 4'd0};
      vecs[4]  = '{1'b1, 6'h3F, 1'b1, 3'd0, 1'b0, 6'h00, 4'd0};
      vecs[5]  = '{1'b1, 6'h3F, 1'b1, 3'd1, 1'b1, 6'h01, 4'd0};
      vecs[6]  = '{1'b1, 6'h3F, 1'b1, 3'd2, 1'b1, 6'h02, 4'd1};
      vecs[7]  = '{1'b1, 6'h3F, 1'b1, 3'd3, 1'b1, 6'h04, 4'd2};
      vecs[8]  = '{1'b1, 6'h3F, 1'b1, 3'd4, 1'b1, 6'h08, 4'd3};
      vecs[9]  = '{1'b1, 6'h3F, 1'b1, 3'd5, 1'b1, 6'h10, 4'd4};
      vecs[10] = '{1'b1, 6'h3F, 1'b1, 3'd6, 1'b1, 6'h20, 4'd5};
      vecs[11] = '{1'b1, 6'h00, 1'b1, 3'd1, 1'b1, 6'h01, 4'd6};
      vecs[12] = '{1'b1, 6'h00, 1'b1, 3'd0, 1'b0, 6'h00, 4'd7};
      vecs[13] = '{1'b1, 6'h04, 1'b0, 3'd0, 1'b0, 6'h00, 4'd7};
      vecs[14] = '{1'b1, 6'h04, 1'b0, 3'd3, 1'b1, 6'h00, 4'd7};
      vecs[15] = '{1'b1, 6'h05, 1'b0, 3'd3, 1'b1, 6'h00, 4'd7};
      vecs[16] = '{1'b1, 6'h04, 1'b0, 3'd3, 1'b1, 6'h00, 4'd7};
      vecs[17] = '{1'b1, 6'h00, 1'b1, 3'd3, 1'b1, 6'h04, 4'd7};
      vecs[18] = '{1'b1, 6'h00, 1'b1, 3'd0, 1'b0, 6'h00, 4'd8};
      vecs[19] = '{1'b1, 6'h04, 1'b0, 3'd0, 1'b0, 6'h00, 4'd8};
      vecs[20] = '{1'b1, 6'h00, 1'b0, 3'd3, 1'b1, 6'h00, 4'd8};
      vecs[21] = '{1'b1, 6'h0C, 1'b0, 3'd0, 1'b0, 6'h00, 4'd8};
      vecs[22] = '{1'b1, 6'h0C, 1'b1, 3'd4, 1'b1, 6'h08, 4'd8};
      vecs[23] = '{1'b1, 6'h00, 1'b1, 3'd3, 1'b1, 6'h04, 4'd9};
      vecs[24] = '{1'b1, 6'h00, 1'b1, 3'd0, 1'b0, 6'h00, 4'd10};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);

      // Vector i drives inputs for one cycle and checks outputs mid-cycle.
      for (int i = 0; i < 25; i++) begin
         #1;
         rst_n     = vecs[i].rst_n;
         req       = vecs[i].req;
         out_ready = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("v%0d sel", i), 32'(sel), 32'(vecs[i].sel));
         check($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].valid));
         check($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].ack));
         check($sformatf("v%0d cnt", i), 32'(xfer_cnt), 32'(vecs[i].cnt));
         if (vecs[i].valid)
            check($sformatf("v%0d data", i), out_data, exp_data(vecs[i].sel));
         @(posedge clk);
      end

      // Counter wrap: 16 back-to-back transfers from reset.
      #1;
      rst_n = 1'b0;
      req = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req = 6'h3F;
      out_ready = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check($sformatf("wrap ack%0d", k), 32'(ack), 32'(6'b000001 << (k % 6)));
         if (k == 15) check("wrap cnt15", 32'(xfer_cnt), 32'd15);
         @(posedge clk);
      end
      @(negedge clk);
      check("wrap cnt0", 32'(xfer_cnt), 32'd0);
      check("wrap sel", 32'(sel), 32'd5);
      check("wrap valid", 32'(out_valid), 32'd1);

      // Asynchronous reset mid-transfer.
      #1;
      rst_n = 1'b0;
      #1;
      check("rst sel", 32'(sel), 32'd0);
      check("rst valid", 32'(out_valid), 32'd0);
      check("rst ack", 32'(ack), 32'd0);
      @(posedge clk);
      #1;
      req = '0;
      rst_n = 1'b1;

`ifdef MUX6_ARB_LOCK_EN
      // Lock holds A through three handshakes, then rotates to B.
      @(posedge clk);
      #1;
      req = 6'b000011;
      lock = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("lock sel%0d", k), 32'(sel), 32'd1);
         check($sformatf("lock ack%0d", k), 32'(ack), 32'h01);
         @(posedge clk);
      end
      #1;
      lock = 1'b0;
      @(negedge clk);
      check("unlock sel", 32'(sel), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("rotate sel", 32'(sel), 32'd2);
      #1;
      req = '0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
